zap_mem_arbiter: RTL and testbench

- Shares one single-ported memory bus between the ZAP instruction-fetch port (PC side) and the load/store data port.
- Sits between zap_top and a single-ported memory or cache model, and replaces the dual-ported unified cache arrangement.
- Data accesses have priority. A starvation counter forces a fetch grant after a bounded run of data grants.
- Provides core-facing stall, valid and abort signalling with the same meaning zap_top already expects.

---
 rtl/zap_mem_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_zap_mem_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zap_mem_arbiter.sv
// zap_mem_arbiter: shares one single-ported memory bus between the ZAP
// instruction-fetch port and the load/store data port.
module zap_mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              i_clk,
    input  logic              i_reset_n,

    input  logic              i_d_rd_en,
    input  logic              i_d_wr_en,
    input  logic [ADDR_W-1:0] i_d_address,
    input  logic [DATA_W-1:0] i_d_wr_data,
    output logic [DATA_W-1:0] o_d_rd_data,
    output logic              o_d_stall,
    output logic              o_d_abort,

    input  logic              i_i_req,
    input  logic [ADDR_W-1:0] i_i_address,
    output logic [DATA_W-1:0] o_i_instruction,
    output logic              o_i_valid,
    output logic              o_i_abort,

    output logic              o_m_req,
    output logic              o_m_we,
    output logic [ADDR_W-1:0] o_m_address,
    output logic [DATA_W-1:0] o_m_wr_data,
    input  logic              i_m_ack,
    input  logic [DATA_W-1:0] i_m_rd_data,
    input  logic              i_m_err,

    output logic              o_grant_data
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] C_SMAX = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BUSY_D = 2'd1,
        S_BUSY_I = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [CNT_W-1:0]  r_starve;
    logic [CNT_W-1:0]  w_starve_nxt;

    logic              r_m_req;
    logic              r_m_we;
    logic [ADDR_W-1:0] r_m_address;
    logic [DATA_W-1:0] r_m_wr_data;

    logic              r_d_done;
    logic              r_d_err;
    logic [DATA_W-1:0] r_d_rd_data;

    logic              r_i_done;
    logic              r_i_err;
    logic [DATA_W-1:0] r_i_instruction;

    logic              w_d_req;
    logic              w_d_elig;
    logic              w_i_elig;
    logic              w_i_match;
    logic              w_grant_d;
    logic              w_grant_i;
    logic              w_d_ack;
    logic              w_i_ack;
    logic              w_busy_ack;
    logic [DATA_W-1:0] w_rd_data;

    // A done pulse blocks re-granting the side the core is retiring.
    assign w_d_req   = i_d_rd_en | i_d_wr_en;
    assign w_d_elig  = w_d_req & ~r_d_done;
    assign w_i_elig  = i_i_req & ~r_i_done;
    assign w_i_match = i_i_req & (i_i_address == r_m_address);

    assign w_busy_ack = i_m_ack & (r_state != S_IDLE);
    assign w_d_ack    = i_m_ack & (r_state == S_BUSY_D);
    assign w_i_ack    = i_m_ack & (r_state == S_BUSY_I) & w_i_match;
    assign w_rd_data  = i_m_err ? '0 : i_m_rd_data;

    always_comb begin
        w_state_nxt = r_state;
        w_grant_d   = 1'b0;
        w_grant_i   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_d_elig && !(w_i_elig && (r_starve == C_SMAX))) begin
                    w_grant_d   = 1'b1;
                    w_state_nxt = S_BUSY_D;
                end else if (w_i_elig) begin
                    w_grant_i   = 1'b1;
                    w_state_nxt = S_BUSY_I;
                end
            end
            S_BUSY_D: begin
                if (i_m_ack) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_BUSY_I: begin
                // A redirected or dropped fetch just falls back to IDLE.
                if (i_m_ack) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_starve_nxt = r_starve;
        if (w_grant_i) begin
            w_starve_nxt = '0;
        end else if (w_grant_d && w_i_elig && (r_starve != C_SMAX)) begin
            w_starve_nxt = r_starve + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state  <= S_IDLE;
            r_starve <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_starve <= w_starve_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_m_req     <= 1'b0;
            r_m_we      <= 1'b0;
            r_m_address <= '0;
            r_m_wr_data <= '0;
        end else if (w_grant_d) begin
            r_m_req     <= 1'b1;
            r_m_we      <= i_d_wr_en;
            r_m_address <= i_d_address;
            r_m_wr_data <= i_d_wr_data;
        end else if (w_grant_i) begin
            r_m_req     <= 1'b1;
            r_m_we      <= 1'b0;
            r_m_address <= i_i_address;
        end else if (w_busy_ack) begin
            r_m_req     <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_d_done    <= 1'b0;
            r_d_err     <= 1'b0;
            r_d_rd_data <= '0;
        end else begin
            r_d_done <= w_d_ack;
            if (w_d_ack) begin
                r_d_err     <= i_m_err;
                r_d_rd_data <= w_rd_data;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_i_done        <= 1'b0;
            r_i_err         <= 1'b0;
            r_i_instruction <= '0;
        end else begin
            r_i_done <= w_i_ack;
            if (w_i_ack) begin
                r_i_err         <= i_m_err;
                r_i_instruction <= w_rd_data;
            end
        end
    end

    assign o_m_req         = r_m_req;
    assign o_m_we          = r_m_we;
    assign o_m_address     = r_m_address;
    assign o_m_wr_data     = r_m_wr_data;

    assign o_d_rd_data     = r_d_rd_data;
    assign o_d_stall       = w_d_req & ~r_d_done;
    assign o_d_abort       = r_d_done & r_d_err;

    assign o_i_instruction = r_i_instruction;
    assign o_i_valid       = r_i_done;
    assign o_i_abort       = r_i_done & r_i_err;

    assign o_grant_data    = (r_state == S_BUSY_D);

endmodule

// File: tb/tb_zap_mem_arbiter.sv
// tb_zap_mem_arbiter: directed and random checks of zap_mem_arbiter
// against a transaction-level reference model.
module tb_zap_mem_arbiter;

    localparam int SMAX = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_d_rd_en = 1'b0;
    logic        i_d_wr_en = 1'b0;
    logic [31:0] i_d_address = '0;
    logic [31:0] i_d_wr_data = '0;
    logic [31:0] o_d_rd_data;
    logic        o_d_stall;
    logic        o_d_abort;
    logic        i_i_req = 1'b0;
    logic [31:0] i_i_address = '0;
    logic [31:0] o_i_instruction;
    logic        o_i_valid;
    logic        o_i_abort;
    logic        o_m_req;
    logic        o_m_we;
    logic [31:0] o_m_address;
    logic [31:0] o_m_wr_data;
    logic        i_m_ack = 1'b0;
    logic [31:0] i_m_rd_data = '0;
    logic        i_m_err = 1'b0;
    logic        o_grant_data;

    always #5 clk = ~clk;

    zap_mem_arbiter #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .STARVE_MAX(SMAX)
    ) dut (
        .i_clk          (clk),
        .i_reset_n      (rst_n),
        .i_d_rd_en      (i_d_rd_en),
        .i_d_wr_en      (i_d_wr_en),
        .i_d_address    (i_d_address),
        .i_d_wr_data    (i_d_wr_data),
        .o_d_rd_data    (o_d_rd_data),
        .o_d_stall      (o_d_stall),
        .o_d_abort      (o_d_abort),
        .i_i_req        (i_i_req),
        .i_i_address    (i_i_address),
        .o_i_instruction(o_i_instruction),
        .o_i_valid      (o_i_valid),
        .o_i_abort      (o_i_abort),
        .o_m_req        (o_m_req),
        .o_m_we         (o_m_we),
        .o_m_address    (o_m_address),
        .o_m_wr_data    (o_m_wr_data),
        .i_m_ack        (i_m_ack),
        .i_m_rd_data    (i_m_rd_data),
        .i_m_err        (i_m_err),
        .o_grant_data   (o_grant_data)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Reference model: at most one transaction in flight.
    bit          mb_busy;
    bit          mb_data;
    bit          mb_we;
    logic [31:0] mb_addr;
    logic [31:0] mb_wdata;
    bit          md_done;
    bit          md_err;
    logic [31:0] md_rdata;
    bit          mi_done;
    bit          mi_err;
    logic [31:0] mi_instr;
    int          m_starve;
    int          ws_left;

    int          cfg_waits;
    bit          cfg_err;
    logic [31:0] cfg_rdata;
    bit          cfg_spur;
    bit          rnd_mem;
    string       glog;

    task automatic model_reset();
        mb_busy  = 0;
        mb_data  = 0;
        mb_we    = 0;
        mb_addr  = '0;
        mb_wdata = '0;
        md_done  = 0;
        md_err   = 0;
        md_rdata = '0;
        mi_done  = 0;
        mi_err   = 0;
        mi_instr = '0;
        m_starve = 0;
        ws_left  = 0;
    endtask

    task automatic compare();
        check("m_req", 32'(o_m_req), 32'(mb_busy));
        check("grant_d", 32'(o_grant_data), 32'(mb_busy && mb_data));
        check("d_stall", 32'(o_d_stall),
              32'((i_d_rd_en || i_d_wr_en) && !md_done));
        check("d_abort", 32'(o_d_abort), 32'(md_done && md_err));
        check("d_rdata", o_d_rd_data, md_rdata);
        check("i_valid", 32'(o_i_valid), 32'(mi_done));
        check("i_abort", 32'(o_i_abort), 32'(mi_done && mi_err));
        check("i_instr", o_i_instruction, mi_instr);
        if (mb_busy) begin
            check("m_addr", o_m_address, mb_addr);
            check("m_we", 32'(o_m_we), 32'(mb_we));
            if (mb_we) check("m_wdata", o_m_wr_data, mb_wdata);
        end
    endtask

    // Drive memory response, advance the model, clock, then compare.
    task automatic cycle();
        bit ack, d_el, i_el, nd, ni;
        ack = 0;
        if (mb_busy) begin
            if (ws_left == 0) ack = 1;
            else ws_left--;
        end else begin
            ack = cfg_spur;
        end
        if (rnd_mem) begin
            i_m_rd_data = $urandom;
            i_m_err     = ($urandom_range(0, 7) == 0);
        end else begin
            i_m_rd_data = cfg_rdata;
            i_m_err     = cfg_err;
        end
        i_m_ack = ack;

        d_el = (i_d_rd_en || i_d_wr_en) && !md_done;
        i_el = i_i_req && !mi_done;
        nd = 0;
        ni = 0;
        if (mb_busy) begin
            if (ack) begin
                mb_busy = 0;
                if (mb_data) begin
                    md_rdata = i_m_err ? 32'h0 : i_m_rd_data;
                    md_err   = i_m_err;
                    nd       = 1;
                end else if (i_i_req && i_i_address == mb_addr) begin
                    mi_instr = i_m_err ? 32'h0 : i_m_rd_data;
                    mi_err   = i_m_err;
                    ni       = 1;
                end
            end
        end else if (d_el && (!i_el || m_starve < SMAX)) begin
            mb_busy  = 1;
            mb_data  = 1;
            mb_we    = i_d_wr_en;
            mb_addr  = i_d_address;
            mb_wdata = i_d_wr_data;
            if (i_el) m_starve = (m_starve + 1 > SMAX) ? SMAX : m_starve + 1;
            ws_left  = rnd_mem ? int'($urandom_range(0, 3)) : cfg_waits;
            glog     = {glog, "D"};
        end else if (i_el) begin
            mb_busy  = 1;
            mb_data  = 0;
            mb_we    = 0;
            mb_addr  = i_i_address;
            m_starve = 0;
            ws_left  = rnd_mem ? int'($urandom_range(0, 3)) : cfg_waits;
            glog     = {glog, "I"};
        end
        md_done = nd;
        mi_done = ni;

        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    initial begin
        int   nvalid;
        bit   seen80, after80;
        logic [31:0] instr;
        model_reset();
        cfg_waits = 0;
        cfg_err   = 0;
        cfg_rdata = '0;
        cfg_spur  = 0;
        rnd_mem   = 0;
        glog      = "";

        repeat (2) @(negedge clk);
        check("rst_m_req", 32'(o_m_req), 32'h0);
        check("rst_m_we", 32'(o_m_we), 32'h0);
        check("rst_m_addr", o_m_address, 32'h0);
        check("rst_m_wdata", o_m_wr_data, 32'h0);
        check("rst_d_rdata", o_d_rd_data, 32'h0);
        check("rst_d_stall", 32'(o_d_stall), 32'h0);
        check("rst_i_valid", 32'(o_i_valid), 32'h0);
        check("rst_i_instr", o_i_instruction, 32'h0);
        check("rst_grant_d", 32'(o_grant_data), 32'h0);
        rst_n = 1'b1;

        // Single zero-wait read
        i_d_rd_en   = 1;
        i_d_address = 32'h100;
        cfg_rdata   = 32'hDEADBEEF;
        cycle();
        check("rd_req_c1", 32'(o_m_req), 32'h1);
        check("rd_addr_c1", o_m_address, 32'h100);
        cycle();
        check("rd_data_c2", o_d_rd_data, 32'hDEADBEEF);
        check("rd_stall_c2", 32'(o_d_stall), 32'h0);
        cycle();
        check("rd_no_reissue", 32'(o_m_req), 32'h0);
        i_d_rd_en = 0;
        cycle();

        // Read+write together is a write
        i_d_rd_en   = 1;
        i_d_wr_en   = 1;
        i_d_address = 32'h200;
        i_d_wr_data = 32'h12345678;
        cfg_rdata   = 32'hA5A5A5A5;
        cycle();
        check("wr_we", 32'(o_m_we), 32'h1);
        check("wr_wdata", o_m_wr_data, 32'h12345678);
        cycle();
        check("wr_rdata_cap", o_d_rd_data, 32'hA5A5A5A5);
        check("wr_stall", 32'(o_d_stall), 32'h0);
        i_d_rd_en = 0;
        i_d_wr_en = 0;
        cycle();

        // Bus error on a read
        i_d_rd_en   = 1;
        i_d_address = 32'h300;
        cfg_err     = 1;
        cycle();
        cycle();
        check("err_abort", 32'(o_d_abort), 32'h1);
        check("err_rdata", o_d_rd_data, 32'h0);
        check("err_stall", 32'(o_d_stall), 32'h0);
        i_d_rd_en = 0;
        cfg_err   = 0;
        cycle();
        check("err_abort_end", 32'(o_d_abort), 32'h0);

        // PC redirect during a slow fetch
        i_i_req     = 1;
        i_i_address = 32'h40;
        cfg_waits   = 3;
        cfg_rdata   = 32'h0BAD0040;
        cycle();
        check("redir_addr40", o_m_address, 32'h40);
        i_i_address = 32'h80;
        cfg_waits   = 0;
        cfg_rdata   = 32'hCAFE0080;
        nvalid  = 0;
        seen80  = 0;
        after80 = 0;
        instr   = '0;
        for (int k = 0; k < 12; k++) begin
            if (i_i_req) begin
                cycle();
                if (o_m_req && o_m_address == 32'h80) seen80 = 1;
                if (o_i_valid) begin
                    nvalid++;
                    after80 = seen80;
                    instr   = o_i_instruction;
                    i_i_req = 0;
                end
            end
        end
        check("redir_valid_cnt", 32'(nvalid), 32'h1);
        check("redir_after80", 32'(after80), 32'h1);
        check("redir_instr", instr, 32'hCAFE0080);
        i_i_req = 0;
        cycle();
        cycle();

        // Starvation: fetch drops only in data-retire cycles
        glog        = "";
        nvalid      = 0;
        i_d_rd_en   = 1;
        i_d_address = 32'h400;
        i_i_address = 32'h44;
        for (int k = 0; k < 24; k++) begin
            i_i_req = !md_done;
            cycle();
            if (o_i_valid) nvalid++;
        end
        check("starve_seq", 32'(glog.substr(0, 4) == "DDDDI"), 32'h1);
        check("starve_ivalid", 32'(nvalid > 0), 32'h1);
        i_d_rd_en = 0;
        i_i_req   = 0;
        cycle();
        cycle();

        // Reset in the middle of a data transaction
        i_d_rd_en   = 1;
        i_d_address = 32'h500;
        cfg_waits   = 5;
        cycle();
        check("midrst_busy", 32'(o_m_req), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_mreq_async", 32'(o_m_req), 32'h0);
        check("midrst_grant_async", 32'(o_grant_data), 32'h0);
        model_reset();
        i_d_rd_en = 0;
        @(negedge clk);
        rst_n     = 1'b1;
        cfg_waits = 0;
        cfg_spur  = 1;
        cfg_rdata = 32'h5EE5_5EE5;
        cycle();
        cfg_spur  = 0;
        cycle();
        check("late_ack_dabort", 32'(o_d_abort), 32'h0);
        check("late_ack_ivalid", 32'(o_i_valid), 32'h0);
        check("late_ack_rdata", o_d_rd_data, 32'h0);

        // Randomised traffic
        rnd_mem = 1;
        for (int k = 0; k < 2400; k++) begin
            if ($urandom_range(0, 3) == 0) i_d_rd_en = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 5) == 0) i_d_wr_en = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0) i_d_address = 32'h1000 + ($urandom_range(0, 15) << 2);
            i_d_wr_data = $urandom;
            if ((k / 200) % 2 == 1) begin
                i_i_req = !md_done;
            end else if ($urandom_range(0, 3) == 0) begin
                i_i_req = ($urandom_range(0, 3) != 0);
            end
            if ($urandom_range(0, 7) == 0) i_i_address = 32'h40 + ($urandom_range(0, 2) << 2);
            cfg_spur = ($urandom_range(0, 9) == 0);
            cycle();
        end

        rnd_mem   = 0;
        cfg_spur  = 0;
        i_d_rd_en = 0;
        i_d_wr_en = 0;
        i_i_req   = 0;
        repeat (6) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
